// File: rtl/pulse_gen.sv
// Programmable pulse-train generator: continuous or N-pulse burst, period/width in clk cycles.
// Latency: start sampled at edge T gives busy/pulse at T+1; settings loaded in RUN apply at the next period wrap.
// Backpressure: none; ena low freezes counters and holds pulse, stop aborts on the next clk.
module pulse_gen #(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   width,
  input  logic [BURST_W-1:0] burst_num,
  input  logic               load,
  input  logic               start,
  input  logic               stop,
  output logic               pulse,
  output logic               busy,
  output logic               done,
  output logic [31:0]        pulse_cnt,
  output logic               cfg_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]         state;
  logic [CNT_W-1:0]   per_s;
  logic [CNT_W-1:0]   wid_s;
  logic [CNT_W-1:0]   per_p;
  logic [CNT_W-1:0]   wid_p;
  logic               pend;
  logic [CNT_W-1:0]   cnt;
  logic [BURST_W-1:0] bst_s;

  logic               ld_ok;
  logic [CNT_W-1:0]   ld_wid;
  logic [CNT_W-1:0]   per_m1;
  logic               wrap;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   nxt_per;
  logic [CNT_W-1:0]   nxt_wid;
  logic [31:0]        pc_inc;
  logic               burst_end;

  always_comb begin
    ld_ok   = load && (period >= CNT_W'(2));
    // Width is clamped so each period keeps at least one low cycle.
    ld_wid  = (width > period - CNT_W'(1)) ? period - CNT_W'(1) : width;
    per_m1  = per_s - CNT_W'(1);
    wrap    = (cnt == per_m1);
    cnt_inc = cnt + CNT_W'(1);
    nxt_per = per_s;
    nxt_wid = wid_s;
    if (ld_ok) begin
      nxt_per = period;
      nxt_wid = ld_wid;
    end else if (pend) begin
      nxt_per = per_p;
      nxt_wid = wid_p;
    end
    pc_inc    = pulse_cnt + 32'd1;
    burst_end = (bst_s != '0) && (pc_inc == 32'(bst_s));
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      per_s     <= CNT_W'(2);
      wid_s     <= CNT_W'(1);
      per_p     <= '0;
      wid_p     <= '0;
      pend      <= 1'b0;
      cnt       <= '0;
      bst_s     <= '0;
      pulse     <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
      cfg_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        cfg_err <= (period < CNT_W'(2));
      end

      if (stop) begin
        state <= IDLE;
        pulse <= 1'b0;
        pend  <= 1'b0;
        if (ld_ok) begin
          per_s <= period;
          wid_s <= ld_wid;
        end
      end else if (state == IDLE) begin
        if (ld_ok) begin
          per_s <= period;
          wid_s <= ld_wid;
        end
        if (start && ena) begin
          state     <= RUN;
          cnt       <= '0;
          pulse_cnt <= '0;
          bst_s     <= burst_num;
          pend      <= 1'b0;
          pulse     <= ld_ok ? (ld_wid != '0) : (wid_s != '0);
        end
      end else begin
        if (ena && wrap) begin
          // New settings take effect exactly at the period boundary.
          cnt       <= '0;
          pulse_cnt <= pc_inc;
          per_s     <= nxt_per;
          wid_s     <= nxt_wid;
          pend      <= 1'b0;
          if (burst_end) begin
            state <= IDLE;
            done  <= 1'b1;
            pulse <= 1'b0;
          end else begin
            pulse <= (nxt_wid != '0);
          end
        end else begin
          if (ena) begin
            cnt   <= cnt_inc;
            pulse <= (cnt_inc < wid_s);
          end
          if (ld_ok) begin
            pend  <= 1'b1;
            per_p <= period;
            wid_p <= ld_wid;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Testbench for pulse_gen: table of load settings, directed corner sequences, random runs vs. arithmetic model.
module tb_pulse_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic        load = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] period = '0;
  logic [31:0] width = '0;
  logic [15:0] burst_num = '0;
  logic        pulse;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [31:0] pulse_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int p;
    int w;
    int exp_hi;
    int exp_per;
    bit exp_err;
  } vec_t;

  vec_t vt[8];

  int  mism, nbusy, rises, t, hi_len, next_rise, k, p, w, we, b;
  bit  prev, running, exp_done, en, st, exp_p;
  bit  s[0:39];

  pulse_gen #(.CNT_W(32), .BURST_W(16)) dut (
    .clk(clk), .rst(rst), .ena(ena), .period(period), .width(width),
    .burst_num(burst_num), .load(load), .start(start), .stop(stop),
    .pulse(pulse), .busy(busy), .done(done), .pulse_cnt(pulse_cnt),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int lp, input int lw);
    period = lp;
    width  = lw;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic do_start(input int nb);
    burst_num = 16'(nb);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic do_stop;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{10, 3, 3, 10, 1'b0};
    vt[1] = '{8, 12, 7, 8, 1'b0};
    vt[2] = '{1, 5, 7, 8, 1'b1};
    vt[3] = '{6, 2, 2, 6, 1'b0};
    vt[4] = '{4, 0, 0, 4, 1'b0};
    vt[5] = '{0, 0, 0, 4, 1'b1};
    vt[6] = '{2, 9, 1, 2, 1'b0};
    vt[7] = '{3, 3, 2, 3, 1'b0};

    // Reset state
    ena = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_pulse", pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", pulse_cnt, 0);
    check("rst_err", cfg_err, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Table: load in IDLE, then check cfg_err and three periods of waveform
    for (int i = 0; i < 8; i++) begin
      do_load(vt[i].p, vt[i].w);
      check($sformatf("tbl%0d_err", i), cfg_err, 32'(vt[i].exp_err));
      do_start(0);
      mism = 0;
      for (int j = 0; j < 3 * vt[i].exp_per; j++) begin
        if (j > 0) tick();
        if (pulse !== ((j % vt[i].exp_per) < vt[i].exp_hi)) mism++;
      end
      check($sformatf("tbl%0d_wave", i), mism, 0);
      check($sformatf("tbl%0d_cnt", i), pulse_cnt, 2);
      do_stop();
    end

    // Burst of 4 pulses at 5/2
    do_load(5, 2);
    do_start(4);
    nbusy = 0; rises = 0; prev = 1'b0; t = 0;
    while (busy && t < 100) begin
      if (pulse && !prev) rises++;
      prev = pulse;
      nbusy++;
      tick();
      t++;
    end
    check("burst_busy_len", nbusy, 20);
    check("burst_done", done, 1);
    check("burst_pulse_low", pulse, 0);
    check("burst_rises", rises, 4);
    check("burst_cnt", pulse_cnt, 4);
    tick();
    check("burst_done_1cyc", done, 0);

    // Mid-period loads (last wins) and a load on the wrap cycle
    for (int v = 0; v < 2; v++) begin
      do_load(10, 3);
      do_start(0);
      mism = 0;
      for (int j = 0; j < 40; j++) begin
        exp_p = (j < 10) ? (j < 3) : (((j - 10) % 6) < 2);
        if (pulse !== exp_p) mism++;
        load = 1'b0;
        if (v == 0 && j == 3) begin period = 7; width = 1; load = 1'b1; end
        if (v == 0 && j == 5) begin period = 6; width = 2; load = 1'b1; end
        if (v == 1 && j == 9) begin period = 6; width = 2; load = 1'b1; end
        if (j < 39) tick();
      end
      load = 1'b0;
      check($sformatf("reload%0d_wave", v), mism, 0);
      do_stop();
      check($sformatf("reload%0d_stop_pulse", v), pulse, 0);
      check($sformatf("reload%0d_stop_busy", v), busy, 0);
      check($sformatf("reload%0d_stop_cnt", v), pulse_cnt, 5);
    end

    // ena low for 5 cycles during the high phase
    do_load(10, 3);
    ena = 1'b1;
    do_start(0);
    for (int j = 0; j < 17; j++) begin
      s[j] = pulse;
      ena = (j >= 1 && j <= 5) ? 1'b0 : 1'b1;
      if (j < 16) tick();
    end
    ena = 1'b1;
    hi_len = 0;
    while (hi_len < 17 && s[hi_len]) hi_len++;
    next_rise = 0;
    for (int j = 16; j > 0; j--) if (s[j] && !s[j-1]) next_rise = j;
    check("ena_high_len", hi_len, 8);
    check("ena_period", next_rise, 15);

    // Stop during the high phase
    check("pre_stop_pulse", pulse, 1);
    do_stop();
    check("stop_pulse", pulse, 0);
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    check("stop_keep_cnt", pulse_cnt, 1);
    mism = 0;
    repeat (3) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) mism++;
    end
    check("stop_no_done", mism, 0);

    // start+stop together, and start with ena low, both ignored
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    check("startstop_pulse", pulse, 0);
    ena = 1'b0;
    do_start(0);
    ena = 1'b1;
    check("start_noena_busy", busy, 0);

    // Asynchronous reset mid-run
    do_load(1, 0);
    check("bad_load_err", cfg_err, 1);
    do_start(0);
    tick(); tick();
    check("prerst_pulse", pulse, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_pulse", pulse, 0);
    check("arst_busy", busy, 0);
    check("arst_cnt", pulse_cnt, 0);
    check("arst_err", cfg_err, 0);
    check("arst_done", done, 0);
    #2 rst = 1'b1;
    tick();
    do_start(0);
    mism = 0;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) tick();
      if (pulse !== (j % 2 == 0)) mism++;
    end
    check("rst_shadow_wave", mism, 0);
    do_stop();

    // Random runs vs. enabled-cycle arithmetic model
    for (int it = 0; it < 40; it++) begin
      p  = $urandom_range(12, 2);
      w  = $urandom_range(p + 2, 0);
      b  = $urandom_range(4, 0);
      we = (w > p - 1) ? p - 1 : w;
      ena = 1'b1;
      do_load(p, w);
      do_start(b);
      k = 0; running = 1'b1; exp_done = 1'b0;
      check("rnd_start_busy", busy, 1);
      check("rnd_start_pulse", pulse, 32'(we > 0));
      for (int c = 0; c < 60; c++) begin
        en = ($urandom_range(9, 0) != 0);
        st = ($urandom_range(49, 0) == 0);
        ena = en;
        stop = st;
        tick();
        stop = 1'b0;
        exp_done = 1'b0;
        if (st) begin
          running = 1'b0;
        end else if (running && en) begin
          k++;
          if (b != 0 && k == b * p) begin
            running = 1'b0;
            exp_done = 1'b1;
          end
        end
        check($sformatf("rnd%0d_busy", it), busy, 32'(running));
        check($sformatf("rnd%0d_pulse", it), pulse, 32'(running && ((k % p) < we)));
        check($sformatf("rnd%0d_done", it), done, 32'(exp_done));
        check($sformatf("rnd%0d_cnt", it), pulse_cnt, k / p);
      end
      ena = 1'b1;
      do_stop();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
# pulse_gen

Programmable pulse-train generator: the transmit counterpart of the period/width measurement block. Produces a clean rectangular `pulse` whose period and high width are given in clk cycles, either continuously or as a burst of N pulses. New settings can be applied glitch-free at period boundaries. The bench uses it for stimulus and loopback into the measurement path; the board uses it to drive external timing outputs.

## Interface
- `CNT_W`, 32: width of the period and width values and of the internal period counter.
- `BURST_W`, 16: width of the burst length.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  clock enable; low freezes all counters and holds `pulse` at its current level.
- `period`  in  CNT_W  requested period in clk cycles.
- `width`  in  CNT_W  requested high time in clk cycles.
- `burst_num`  in  BURST_W  pulses per burst; 0 means continuous.
- `load`  in  1  one-cycle strobe; latch `period`/`width` into the shadow registers.
- `start`  in  1  one-cycle strobe; begin generation from IDLE.
- `stop`  in  1  one-cycle strobe; abort immediately.
- `pulse`  out  1  generated pulse, registered.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle strobe at burst completion.
- `pulse_cnt`  out  32  completed periods since the last start.
- `cfg_err`  out  1  sticky; set when a `period` value < 2 is loaded; cleared by the next valid load.

## Operation
- Shadow registers `per_s` and `wid_s` hold the active settings. Reset values: `per_s` = 2, `wid_s` = 1.
- Load rules:
  - `load` with `period` < 2: shadows unchanged, `cfg_err` set.
  - Otherwise `per_s` = `period` and `wid_s` = min(`width`, `period`−1). The clamp guarantees at least one low cycle per period, so every period has both edges.
  - `wid_s` = 0 is legal: `pulse` stays low, but periods are still counted.
- Load timing:
  - In IDLE, a load takes effect on the next clk.
  - In RUN, a load sets `pend`. The pending values apply at the next period wrap.
  - A load arriving on the wrap cycle itself applies to the period that starts at that wrap.
  - A second load before the wrap overwrites the pending values; the last one wins.
- States: IDLE and RUN. The counter `cnt` runs 0..`per_s`−1.
- IDLE → RUN on `start` && `ena` && !`stop`.
  - On entry: `cnt` = 0, `pulse_cnt` = 0, and `burst_num` is latched into `bst_s`.
  - `start` while `ena` = 0 is ignored.
- RUN, each enabled cycle:
  - `pulse` <= (`cnt_next` < `wid_s`).
  - At `cnt` = `per_s`−1: `cnt` wraps to 0 and `pulse_cnt` increments. `pulse_cnt` wraps from 2^32−1 to 0.
  - If `bst_s` ≠ 0 and the incremented `pulse_cnt` equals `bst_s`: go to IDLE, `done` = 1 for one cycle, `pulse` = 0.
- `start` while in RUN is ignored.
- `stop` in any state forces IDLE on the next clk:
  - `pulse` = 0, `done` not asserted, `pulse_cnt` keeps its value, pending load discarded.
  - `stop` and `start` in the same cycle: `stop` wins.
- Reset mid-operation returns immediately to IDLE with all reset values. Outputs after reset: `pulse` = 0, `busy` = 0, `done` = 0, `pulse_cnt` = 0, `cfg_err` = 0.

## Timing
- `start` sampled at edge T:
  - `busy` and `pulse` both go high at T+1 when `wid_s` > 0.
  - `pulse` is high for `wid_s` enabled cycles, then low for `per_s`−`wid_s` cycles.
- Rising-edge spacing equals `per_s` exactly. A loopback into the measurement block must read `period` = `per_s` and `width` = `wid_s`.
- Wrap-applied settings change the period beginning at the cycle after the wrap edge. No short or merged pulse is ever produced.
- `done` and the fall of `busy` coincide, one cycle after the last low cycle of the final period.
- `ena` low stretches the current phase by the number of disabled cycles. There is no output glitch.
- All outputs are registered. There is no combinational path from input to output.

## Test plan
- Reset, then load `period` = 10, `width` = 3, `burst_num` = 0, then `start` → `pulse` high 3 cycles and low 7 cycles, repeating; `pulse_cnt` increments every 10 cycles; loopback measurement gives 10 and 3.
- `burst_num` = 4, `period` = 5, `width` = 2 → exactly 4 pulses; `done` for 1 cycle 20 cycles after `start`; `busy` falls at the same edge; `pulse_cnt` = 4.
- Load `width` = 12 with `period` = 8 → `wid_s` = 7, giving high 7 / low 1. Load `period` = 1 → `cfg_err` = 1, previous settings kept. Then load `period` = 6 → `cfg_err` = 0.
- While running 10/3, load 6/2 mid-period, and separately exactly on the wrap cycle → the current period completes as 10/3 (first case), and every period after the applying wrap is 6/2 with no truncated pulse.
- `stop` during the high phase → `pulse` = 0 and IDLE on the next clk, no `done`. `start` and `stop` in the same cycle from IDLE → stays IDLE.
- Deassert `ena` for 5 cycles during the high phase → the high phase lasts `wid_s`+5 cycles and the period lasts `per_s`+5. Assert `rst` mid-run → all outputs return to their reset values asynchronously.
